// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with active-low enable, manual select and round-robin auto-scan.
// Optional build macro MUX_SCAN_SKIP_EN adds a ch_mask input that lets the scan skip disabled channels.
module mux_scan #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 1,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    G,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        C,
  input  logic [N_CH*WIDTH-1:0]   X,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [N_CH-1:0]         ch_mask,
`endif
  output logic [WIDTH-1:0]        Y,
  output logic [SEL_W-1:0]        ch,
  output logic                    valid,
  output logic                    wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt, ptr_base, cur, adv;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_base, cnt_eff;
  logic             wrap_d1, wrap_d1_nxt, wrap_d2, wrap_d2_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [SEL_W-1:0] ch_nxt;
  logic             valid_nxt, wrap_nxt;

`ifdef MUX_SCAN_SKIP_EN
  logic found;

  function automatic int circ(input int a);
    return (a >= N_CH) ? a - N_CH : a;
  endfunction
`endif

  always_comb begin
    state_nxt = G ? IDLE : (mode ? SCAN : MANUAL);
    // A fresh entry into SCAN always starts from pointer 0 with an empty dwell.
    ptr_base  = (state == SCAN) ? ptr : '0;
    cnt_base  = (state == SCAN) ? cnt : '0;
`ifdef MUX_SCAN_SKIP_EN
    if (state_nxt == SCAN && ch_mask == '0) state_nxt = IDLE;
    // cur: the pointer itself if still enabled, else the next enabled channel.
    found = 1'b0;
    cur   = ptr_base;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && ch_mask[circ(int'(ptr_base) + i)]) begin
        cur   = SEL_W'(circ(int'(ptr_base) + i));
        found = 1'b1;
      end
    end
    // adv: next enabled channel after cur; lands back on cur if it is the only one.
    found = 1'b0;
    adv   = cur;
    for (int i = 1; i <= N_CH; i++) begin
      if (!found && ch_mask[circ(int'(cur) + i)]) begin
        adv   = SEL_W'(circ(int'(cur) + i));
        found = 1'b1;
      end
    end
`else
    cur = ptr_base;
    adv = (cur == PTR_LAST) ? '0 : cur + 1'b1;
`endif
    cnt_eff     = (cur != ptr_base) ? '0 : cnt_base;
    y_nxt       = '1;
    ch_nxt      = ch;
    valid_nxt   = 1'b0;
    wrap_nxt    = 1'b0;
    ptr_nxt     = '0;
    cnt_nxt     = '0;
    wrap_d1_nxt = 1'b0;
    wrap_d2_nxt = 1'b0;
    case (state_nxt)
      MANUAL: begin
        if (int'(C) < N_CH) begin
          y_nxt     = X[int'(C)*WIDTH +: WIDTH];
          ch_nxt    = C;
          valid_nxt = 1'b1;
        end
      end
      SCAN: begin
        y_nxt     = X[int'(cur)*WIDTH +: WIDTH];
        ch_nxt    = cur;
        valid_nxt = 1'b1;
        if (cnt_eff == CNT_LAST) begin
          ptr_nxt     = adv;
          wrap_d1_nxt = (adv <= cur);
        end else begin
          ptr_nxt = cur;
          cnt_nxt = cnt_eff + 1'b1;
        end
        // wrap shows one cycle after the first sample of the new pass appears on Y.
        wrap_d2_nxt = wrap_d1;
        wrap_nxt    = wrap_d2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      wrap_d1 <= 1'b0;
      wrap_d2 <= 1'b0;
      Y       <= '1;
      ch      <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      wrap_d1 <= wrap_d1_nxt;
      wrap_d2 <= wrap_d2_nxt;
      Y       <= y_nxt;
      ch      <= ch_nxt;
      valid   <= valid_nxt;
      wrap    <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: vector table, directed corner sequences and
// randomized traffic against a cycle-count reference model.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        g = 1'b1;
  logic        mode = 1'b0;
  logic [1:0]  c = 2'd0;
  logic [31:0] xa = 32'h0;
  logic [23:0] xb = 24'h0;
  logic [7:0]  ya, yb;
  logic [1:0]  cha, chb;
  logic        va, vb, wa, wb;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: edges spent in SCAN since entry, and last reported channel.
  int          ka = 0, kb = 0;
  logic [1:0]  mch_a = 2'd0, mch_b = 2'd0;
  logic [7:0]  ey_a, ey_b;
  logic [1:0]  ec_a, ec_b;
  logic        ev_a, ev_b, ew_a, ew_b;

  always #5 clk = ~clk;

`ifdef MUX_SCAN_SKIP_EN
  logic [3:0]  mask_a = 4'hF;
  logic [2:0]  mask_b = 3'h7;
  logic [3:0]  mask_c = 4'hF;
  logic        g_c = 1'b1;
  logic [7:0]  yc;
  logic [1:0]  chc;
  logic        vc, wc;
`endif

  mux_scan #(.N_CH(4), .WIDTH(8), .SEL_W(2), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .G(g), .mode(mode), .C(c), .X(xa),
`ifdef MUX_SCAN_SKIP_EN
    .ch_mask(mask_a),
`endif
    .Y(ya), .ch(cha), .valid(va), .wrap(wa));

  mux_scan #(.N_CH(3), .WIDTH(8), .SEL_W(2), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .G(g), .mode(mode), .C(c), .X(xb),
`ifdef MUX_SCAN_SKIP_EN
    .ch_mask(mask_b),
`endif
    .Y(yb), .ch(chb), .valid(vb), .wrap(wb));

`ifdef MUX_SCAN_SKIP_EN
  mux_scan #(.N_CH(4), .WIDTH(8), .SEL_W(2), .DWELL(2)) dut_c (
    .clk(clk), .rst(rst), .G(g_c), .mode(1'b1), .C(2'd0), .X(32'hD3C2B1A0),
    .ch_mask(mask_c), .Y(yc), .ch(chc), .valid(vc), .wrap(wc));
`endif

  typedef struct {
    logic       g;
    logic       md;
    logic [1:0] c;
    logic [7:0] y;
    logic [1:0] ch;
    logic       v;
    logic       w;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t row(input logic gg, input logic mm, input logic [1:0] cc,
                               input logic [7:0] y, input logic [1:0] chv,
                               input logic v, input logic w);
    vec_t r;
    r.g = gg; r.md = mm; r.c = cc; r.y = y; r.ch = chv; r.v = v; r.w = w;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: scan position is (edges since entry / dwell) mod channels;
  // wrap is seen one edge after the first channel-0 sample of every later pass.
  task automatic model(input int n_ch, input int dwell, input logic gg, input logic md,
                       input logic [1:0] cc, input logic [31:0] x, input int k_in,
                       input logic [1:0] ch_in, output int k_out, output logic [7:0] y,
                       output logic [1:0] chv, output logic v, output logic w);
    int p;
    y = 8'hFF; chv = ch_in; v = 1'b0; w = 1'b0; k_out = 0;
    p = n_ch * dwell;
    if (!gg && !md) begin
      if (int'(cc) < n_ch) begin
        y = x[int'(cc)*8 +: 8]; chv = cc; v = 1'b1;
      end
    end else if (!gg && md) begin
      chv   = 2'((k_in / dwell) % n_ch);
      y     = x[int'(chv)*8 +: 8];
      v     = 1'b1;
      w     = (k_in > p) && ((k_in - 1) % p == 0);
      k_out = k_in + 1;
    end
  endtask

  task automatic model_reset();
    ka = 0; kb = 0; mch_a = 2'd0; mch_b = 2'd0;
  endtask

  task automatic tick();
    int kn;
    model(4, 4, g, mode, c, xa, ka, mch_a, kn, ey_a, ec_a, ev_a, ew_a);
    ka = kn; mch_a = ec_a;
    model(3, 1, g, mode, c, {8'h0, xb}, kb, mch_b, kn, ey_b, ec_b, ev_b, ew_b);
    kb = kn; mch_b = ec_b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model_a(input string tag);
    check({tag, "_a_y"}, 32'(ya), 32'(ey_a));
    check({tag, "_a_ch"}, 32'(cha), 32'(ec_a));
    check({tag, "_a_valid"}, 32'(va), 32'(ev_a));
    check({tag, "_a_wrap"}, 32'(wa), 32'(ew_a));
  endtask

  task automatic check_model_b(input string tag);
    check({tag, "_b_y"}, 32'(yb), 32'(ey_b));
    check({tag, "_b_ch"}, 32'(chb), 32'(ec_b));
    check({tag, "_b_valid"}, 32'(vb), 32'(ev_b));
    check({tag, "_b_wrap"}, 32'(wb), 32'(ew_b));
  endtask

  // Called at posedge+1: reset must clear outputs before any further clock edge.
  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_y"}, 32'(ya), 32'hFF);
    check({tag, "_ch"}, 32'(cha), 32'h0);
    check({tag, "_valid"}, 32'(va), 32'h0);
    check({tag, "_wrap"}, 32'(wa), 32'h0);
    check({tag, "_b_valid"}, 32'(vb), 32'h0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seq_ch [8];
    logic       seq_w  [8];
    int         n_wrap;

    tbl[0]  = row(0, 0, 0, 8'hA0, 0, 1, 0);  tbl[1]  = row(0, 0, 1, 8'hB1, 1, 1, 0);
    tbl[2]  = row(0, 0, 2, 8'hC2, 2, 1, 0);  tbl[3]  = row(0, 0, 3, 8'hD3, 3, 1, 0);
    tbl[4]  = row(1, 0, 3, 8'hFF, 3, 0, 0);
    tbl[5]  = row(0, 1, 0, 8'hA0, 0, 1, 0);  tbl[6]  = row(0, 1, 0, 8'hA0, 0, 1, 0);
    tbl[7]  = row(0, 1, 0, 8'hA0, 0, 1, 0);  tbl[8]  = row(0, 1, 0, 8'hA0, 0, 1, 0);
    tbl[9]  = row(0, 1, 0, 8'hB1, 1, 1, 0);  tbl[10] = row(0, 1, 0, 8'hB1, 1, 1, 0);
    tbl[11] = row(0, 1, 0, 8'hB1, 1, 1, 0);  tbl[12] = row(0, 1, 0, 8'hB1, 1, 1, 0);
    tbl[13] = row(0, 1, 0, 8'hC2, 2, 1, 0);  tbl[14] = row(0, 1, 0, 8'hC2, 2, 1, 0);
    tbl[15] = row(0, 1, 0, 8'hC2, 2, 1, 0);  tbl[16] = row(0, 1, 0, 8'hC2, 2, 1, 0);
    tbl[17] = row(0, 1, 0, 8'hD3, 3, 1, 0);  tbl[18] = row(0, 1, 0, 8'hD3, 3, 1, 0);
    tbl[19] = row(0, 1, 0, 8'hD3, 3, 1, 0);  tbl[20] = row(0, 1, 0, 8'hD3, 3, 1, 0);
    tbl[21] = row(0, 1, 0, 8'hA0, 0, 1, 0);  tbl[22] = row(0, 1, 0, 8'hA0, 0, 1, 1);
    tbl[23] = row(0, 1, 0, 8'hA0, 0, 1, 0);  tbl[24] = row(0, 1, 0, 8'hA0, 0, 1, 0);
    tbl[25] = row(0, 1, 0, 8'hB1, 1, 1, 0);
    seq_ch = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    seq_w  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset and idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_y", 32'(ya), 32'hFF);
    check("reset_ch", 32'(cha), 32'h0);
    check("reset_valid", 32'(va), 32'h0);
    check("reset_wrap", 32'(wa), 32'h0);
    #3 rst = 1'b0;
    model_reset();
    g = 1'b1; xa = $urandom; xb = 24'($urandom);
    tick();
    check("idle_y", 32'(ya), 32'hFF);
    check("idle_ch", 32'(cha), 32'h0);
    check("idle_valid", 32'(va), 32'h0);
    check_model_b("idle");

    // Manual stepping and a full scan of dut_a from the vector table
    xa = 32'hD3C2B1A0; xb = 24'hC2B1A0;
    for (int i = 0; i < 26; i++) begin
      g = tbl[i].g; mode = tbl[i].md; c = tbl[i].c;
      tick();
      check($sformatf("tbl%0d_y", i), 32'(ya), 32'(tbl[i].y));
      check($sformatf("tbl%0d_ch", i), 32'(cha), 32'(tbl[i].ch));
      check($sformatf("tbl%0d_valid", i), 32'(va), 32'(tbl[i].v));
      check($sformatf("tbl%0d_wrap", i), 32'(wa), 32'(tbl[i].w));
      check_model_b("tbl");
    end

    // Async reset in the middle of a scan
    async_reset_check("arst_scan");

    // DWELL=1, three channels: every edge advances
    g = 1'b0; mode = 1'b1; n_wrap = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("dw1_%0d_ch", i), 32'(chb), 32'(seq_ch[i]));
      check($sformatf("dw1_%0d_wrap", i), 32'(wb), 32'(seq_w[i]));
      check($sformatf("dw1_%0d_y", i), 32'(yb), 32'(xb[int'(seq_ch[i])*8 +: 8]));
      if (wb) n_wrap++;
    end
    check("dw1_wrap_count", 32'(n_wrap), 32'd2);
    mode = 1'b0; c = 2'd3;
    tick();
    check("dw1_badsel_y", 32'(yb), 32'hFF);
    check("dw1_badsel_valid", 32'(vb), 32'h0);
    check_model_a("dw1_badsel");

    // Disable mid-dwell on channel 2, then restart with a full dwell at channel 0
    mode = 1'b1;
    repeat (10) tick();
    check("mid_ch", 32'(cha), 32'd2);
    g = 1'b1;
    tick();
    check("gate_y", 32'(ya), 32'hFF);
    check("gate_valid", 32'(va), 32'h0);
    g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("restart%0d_ch", i), 32'(cha), 32'd0);
      check($sformatf("restart%0d_y", i), 32'(ya), 32'hA0);
    end
    tick();
    check("restart_next_ch", 32'(cha), 32'd1);
    check("restart_next_y", 32'(ya), 32'hB1);

`ifdef MUX_SCAN_SKIP_EN
    begin
      logic [1:0] mseq [6];
      mseq = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
      mask_c = 4'b1010; g_c = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        check($sformatf("skip%0d_ch", i), 32'(chc), 32'(mseq[i]));
        check($sformatf("skip%0d_wrap", i), 32'(wc), (i == 5) ? 32'd1 : 32'd0);
      end
      mask_c = 4'b0000;
      @(posedge clk); #1;
      check("skip_none_valid", 32'(vc), 32'h0);
      check("skip_none_y", 32'(yc), 32'hFF);
    end
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      g = ($urandom_range(0, 24) == 0);
      c = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        xa = $urandom;
        xb = 24'($urandom);
      end
      tick();
      check_model_a("rnd");
      check_model_b("rnd");
      if (i == 200) async_reset_check("arst_rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
